brushless_commutator: RTL
=========================

# brushless_commutator

- Sits directly upstream of the PWM generator in the motor-drive path.
- Synchronizes the three hall-effect sensor inputs and latches the rotor position once per PWM period on `PWM_synch`.
- Maps the latched position to per-phase coil drive selects, and produces the 11-bit `duty` that feeds the PWM generator.
- Handles regenerative braking and, optionally, detects a stuck or invalid hall pattern.

## Interface
Parameters:
- `FAULT_CNT`, default 4: consecutive invalid hall samples, taken on `PWM_synch`, that trip `hall_fault`.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hallGrn`, `hallYlw`, `hallBlu` in 1 each: raw asynchronous hall sensor inputs.
- `brake_n` in 1: synchronous; 0 requests regenerative braking.
- `drive_mag` in 12: unsigned drive magnitude from the torque/PID stage.
- `PWM_synch` in 1: one-clock pulse from the PWM generator, once per 2048-clock period.
- `duty` out 11: duty command to the PWM generator; registered.
- `selGrn`, `selYlw`, `selBlu` out 2 each: phase drive select; registered.
  - 00 = high-Z; 01 = reverse current; 10 = forward current; 11 = regen brake.
- `hall_fault` out 1: sticky hall fault flag; registered.

## Operation
- Each hall input passes through a 2-flop metastability synchronizer (3 bits total).
- Rotation state `rot[2:0]` = {Grn, Ylw, Blu} after the synchronizer.
  - Loaded only on a clock edge where `PWM_synch`=1; held otherwise.
- Commutation table, given as `rot` → Grn/Ylw/Blu selects:
  - 101 → 10/01/00
  - 100 → 10/00/01
  - 110 → 00/10/01
  - 010 → 01/10/00
  - 011 → 01/00/10
  - 001 → 00/01/10
  - 000 or 111 (invalid) → 00/00/00
- Priority of the select outputs, highest first:
  - `hall_fault` → all 00.
  - `brake_n`=0 → all 11, regardless of `rot`.
  - Otherwise, the commutation table.
- Duty arithmetic, unsigned and 11-bit:
  - Fault → 11'h000.
  - Braking → 11'h600.
  - Otherwise → 11'h400 + `drive_mag[11:2]`. Range is 0x400..0x7FF, so no overflow is possible.
- Fault counter (`HALL_FAULT_EN` builds only):
  - Width is $clog2(`FAULT_CNT`+1). Evaluated only on `PWM_synch` edges.
  - Increments when the newly loaded value is invalid; clears to 0 when it is valid.
  - Saturates at `FAULT_CNT`.
  - Reaching `FAULT_CNT` sets `hall_fault`, which is cleared only by `rst_n`.

## Timing
- Reset values:
  - Synchronizer flops = 0; `rot` = 3'b000.
  - All selects = 00; `duty` = 11'h000; `hall_fault` = 0; fault counter = 0.
- Hall latency:
  - The input must be stable 2 clocks before the `PWM_synch` edge to be captured in `rot` on that edge.
  - Selects reflect the new `rot` on the following edge.
  - Total: `rot` update at edge N, selects at edge N+1.
- Commutation changes only once per PWM period: 1–2 clocks after the counter wraps, while `PWM_sig` is being re-armed.
- `brake_n` and `drive_mag` are registered with no `PWM_synch` gating; `duty` and selects follow 1 clock after the input changes.
- Hall change and `PWM_synch` on the same edge: the synchronizer output as it stood before that edge is latched, so the new value is taken next period.
- `brake_n` release: normal commutation from the current `rot` resumes on the next edge. There is no wait for `PWM_synch`.
- `hall_fault` asserts on the edge after the `FAULT_CNT`-th invalid capture; selects and `duty` zero one edge later.
- Reset mid-period: all outputs return to reset values asynchronously.
  - After release, selects stay 00 until the first valid `PWM_synch` capture, because `rot`=000 is invalid.

## Configuration
- `HALL_FAULT_EN` defined:
  - Fault counter and sticky `hall_fault` are built.
  - Invalid states beyond `FAULT_CNT` force all selects to 00 and `duty` to 0.
- Not defined:
  - No counter is built and `hall_fault` is tied 0.
  - Invalid states give only the table's all-00 selects, with `duty` computed normally.

## Test plan
- Reset asserted mid-run → all selects 00, `duty`=0, `hall_fault`=0 immediately.
- Commutation walk: halls stepped 101→100→110→010→011→001, each held for a full period, `drive_mag`=12'h800, `brake_n`=1.
  - Selects follow the table, each changing 1 clock after `PWM_synch`.
  - `duty`=11'h600.
- Hall change 1 clock before `PWM_synch` → old state is used this period; the new state is latched on the next `PWM_synch`.
- `brake_n`=0 with halls=101 → all selects 11 and `duty`=11'h600 one clock later; `brake_n`=1 → 10/01/00 restored next clock.
- Halls held at 111 (`HALL_FAULT_EN`, `FAULT_CNT`=4):
  - `hall_fault` rises after the 4th `PWM_synch`; selects go 00 and `duty` 0.
  - It stays set after halls return to 101 until reset.
- `drive_mag`=12'hFFF → `duty`=11'h7FF; `drive_mag`=12'h003 → `duty`=11'h400.

Source files
------------

// File: rtl/brushless_commutator.sv
// BLDC commutator: hall synchronizer, per-PWM-period rotor latch, phase selects and duty.
// Optional stuck/invalid hall detection is built when HALL_FAULT_EN is defined.
module brushless_commutator #(
    parameter int FAULT_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    input  logic [11:0] drive_mag,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        hall_fault
);

    logic [2:0]  hall_meta;
    logic [2:0]  hall_sync;
    logic [2:0]  rot;
    logic [5:0]  table_sel;
    logic [5:0]  next_sel;
    logic [10:0] next_duty;
    logic [10:0] mag_scaled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_meta <= 3'b000;
            hall_sync <= 3'b000;
            rot       <= 3'b000;
        end else begin
            hall_meta <= {hallGrn, hallYlw, hallBlu};
            hall_sync <= hall_meta;
            if (PWM_synch)
                rot <= hall_sync;
        end
    end

    // Selects packed as {Grn, Ylw, Blu}; 10 = forward, 01 = reverse, 00 = high-Z.
    always_comb begin
        table_sel = 6'b00_00_00;
        case (rot)
            3'b101:  table_sel = 6'b10_01_00;
            3'b100:  table_sel = 6'b10_00_01;
            3'b110:  table_sel = 6'b00_10_01;
            3'b010:  table_sel = 6'b01_10_00;
            3'b011:  table_sel = 6'b01_00_10;
            3'b001:  table_sel = 6'b00_01_10;
            default: table_sel = 6'b00_00_00;
        endcase
    end

    // Top bit of the shifted magnitude is always zero, so 11 bits hold it exactly.
    assign mag_scaled = 11'(drive_mag >> 2);

`ifdef HALL_FAULT_EN
    localparam int CW = $clog2(FAULT_CNT + 1);

    logic [CW-1:0] fault_cnt;
    logic          hall_invalid;

    assign hall_invalid = (hall_sync == 3'b000) || (hall_sync == 3'b111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt  <= '0;
            hall_fault <= 1'b0;
        end else begin
            if (PWM_synch) begin
                if (!hall_invalid)
                    fault_cnt <= '0;
                else if (fault_cnt != CW'(FAULT_CNT))
                    fault_cnt <= fault_cnt + CW'(1);
            end
            if (fault_cnt == CW'(FAULT_CNT))
                hall_fault <= 1'b1;
        end
    end
`else
    assign hall_fault = 1'b0;
`endif

    always_comb begin
        next_sel  = 6'b00_00_00;
        next_duty = 11'h000;
        if (hall_fault) begin
            next_sel  = 6'b00_00_00;
            next_duty = 11'h000;
        end else if (!brake_n) begin
            next_sel  = 6'b11_11_11;
            next_duty = 11'h600;
        end else begin
            next_sel  = table_sel;
            next_duty = 11'h400 + mag_scaled;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selGrn <= 2'b00;
            selYlw <= 2'b00;
            selBlu <= 2'b00;
            duty   <= 11'h000;
        end else begin
            {selGrn, selYlw, selBlu} <= next_sel;
            duty <= next_duty;
        end
    end

endmodule
